// File: rtl/shift_issue_queue_if.sv
// rtl/shift_issue_queue_if.sv - request, shifter and result signal bundle for shift_issue_queue
//
// Groups three signal sets:
//   in_*  : request stream (valid/ready, operand, amount, type, tag)
//   sh_*  : head entry presented to the combinational shifter, sh_result back
//   out_* : registered result stream (valid/ready, result, tag)
// slave modport is the queue itself; master modport is the surrounding
// producer/shifter/consumer environment.
interface shift_issue_queue_if #(
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic [4:0]      in_num;
    logic [1:0]      in_type;
    logic [TAGW-1:0] in_tag;

    logic [31:0]     sh_data;
    logic [4:0]      sh_num;
    logic [1:0]      sh_type;
    logic [31:0]     sh_result;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic [TAGW-1:0] out_tag;

    modport slave (
        input  in_valid, in_data, in_num, in_type, in_tag,
        output in_ready,
        output sh_data, sh_num, sh_type,
        input  sh_result,
        output out_valid, out_result, out_tag,
        input  out_ready
    );

    modport master (
        output in_valid, in_data, in_num, in_type, in_tag,
        input  in_ready,
        input  sh_data, sh_num, sh_type,
        output sh_result,
        input  out_valid, out_result, out_tag,
        output out_ready
    );
endinterface

// File: rtl/shift_issue_queue.sv
// rtl/shift_issue_queue.sv - shift request FIFO feeding an external shifter with a registered result stage
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   flush  : synchronous drop of every queued and output-held request
//   bus    : shift_issue_queue_if.slave (in_* request stream, sh_* shifter
//            operands and result, out_* registered result stream)
//   count  : FIFO occupancy, not counting the output register
module shift_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    shift_issue_queue_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]     data_q [DEPTH];
    logic [31:0]     data_d [DEPTH];
    logic [4:0]      num_q  [DEPTH];
    logic [4:0]      num_d  [DEPTH];
    logic [1:0]      type_q [DEPTH];
    logic [1:0]      type_d [DEPTH];
    logic [TAGW-1:0] tag_q  [DEPTH];
    logic [TAGW-1:0] tag_d  [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_result_q, out_result_d;
    logic [TAGW-1:0] out_tag_q, out_tag_d;

    logic head_valid;
    logic out_free;
    logic push;
    logic pop;

    // in_ready looks only at registered occupancy so a full queue never
    // accepts on the strength of a same-cycle pop.
    assign bus.in_ready   = (count_q != CW'(DEPTH));
    assign head_valid     = (count_q != '0);
    assign out_free       = !out_valid_q || bus.out_ready;
    assign push           = bus.in_valid && bus.in_ready;
    assign pop            = head_valid && out_free;

    assign bus.sh_data    = head_valid ? data_q[rd_ptr_q] : 32'd0;
    assign bus.sh_num     = head_valid ? num_q[rd_ptr_q]  : 5'd0;
    assign bus.sh_type    = head_valid ? type_q[rd_ptr_q] : 2'd0;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_tag    = out_tag_q;
    assign count          = count_q;

    always_comb begin
        data_d       = data_q;
        num_d        = num_q;
        type_d       = type_q;
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = bus.in_data;
                num_d[wr_ptr_q]  = bus.in_num;
                type_d[wr_ptr_q] = bus.in_type;
                tag_d[wr_ptr_q]  = bus.in_tag;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                out_result_d = bus.sh_result;
                out_tag_d    = tag_q[rd_ptr_q];
                out_valid_d  = 1'b1;
                rd_ptr_d     = rd_ptr_q + PW'(1);
            end else if (out_free) begin
                out_valid_d  = 1'b0;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                num_q[i]  <= '0;
                type_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            data_q       <= data_d;
            num_q        <= num_d;
            type_q       <= type_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end
endmodule

// File: tb/tb_shift_issue_queue.sv
// tb/tb_shift_issue_queue.sv - self-checking bench for shift_issue_queue
module tb_shift_issue_queue;
    localparam int DEPTH = 4;
    localparam int TAGW  = 4;

    typedef struct packed {
        logic [31:0]     d;
        logic [4:0]      n;
        logic [1:0]      t;
        logic [TAGW-1:0] tag;
    } req_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [2:0] count;

    shift_issue_queue_if #(.TAGW(TAGW)) bus ();

    shift_issue_queue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational Shifter.
    always_comb begin
        case (bus.sh_type)
            2'b00:   bus.sh_result = bus.sh_data << bus.sh_num;
            2'b01:   bus.sh_result = bus.sh_data >> bus.sh_num;
            2'b10:   bus.sh_result = $signed(bus.sh_data) >>> bus.sh_num;
            default: bus.sh_result = (bus.sh_data >> bus.sh_num) |
                                     (bus.sh_data << (6'd32 - {1'b0, bus.sh_num}));
        endcase
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, obs, exp);
    endtask

    // Reference shift computed arithmetically from the operation's meaning.
    function automatic logic [31:0] ref_shift(input req_t r);
        logic [63:0] p;
        logic [31:0] q;
        p = 64'(r.d) * (64'd1 << r.n);
        case (r.t)
            2'd0: return p[31:0];
            2'd1: return r.d / (32'd1 << r.n);
            2'd2: begin
                if (r.d[31]) begin
                    q = (~r.d) / (32'd1 << r.n);
                    return ~q;
                end
                return r.d / (32'd1 << r.n);
            end
            default: begin
                p = {r.d, r.d};
                p = p / (64'd1 << r.n);
                return p[31:0];
            end
        endcase
    endfunction

    // Model: pending requests plus one output slot.
    req_t            fifo[$];
    bit              m_ov;
    logic [31:0]     m_res;
    logic [TAGW-1:0] m_tag;

    bit   s_valid, s_ordy, s_flush;
    req_t s_req;

    task automatic drive(input bit v, input req_t r, input bit ordy, input bit fl);
        s_valid = v; s_req = r; s_ordy = ordy; s_flush = fl;
        bus.in_valid  = v;
        bus.in_data   = r.d;
        bus.in_num    = r.n;
        bus.in_type   = r.t;
        bus.in_tag    = r.tag;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    task automatic model_edge();
        bit   free, pop, push;
        req_t h;
        if (s_flush) begin
            fifo.delete();
            m_ov = 0;
        end else begin
            free = !m_ov || s_ordy;
            pop  = (fifo.size() != 0) && free;
            push = s_valid && (fifo.size() < DEPTH);
            if (pop) begin
                h     = fifo.pop_front();
                m_res = ref_shift(h);
                m_tag = h.tag;
                m_ov  = 1;
            end else if (free) begin
                m_ov = 0;
            end
            if (push) fifo.push_back(s_req);
        end
    endtask

    task automatic model_reset();
        fifo.delete();
        m_ov = 0; m_res = '0; m_tag = '0;
    endtask

    task automatic check_all();
        req_t h;
        h = (fifo.size() != 0) ? fifo[0] : '0;
        chk("in_ready",   32'(bus.in_ready),   32'(fifo.size() != DEPTH));
        chk("count",      32'(count),          32'(fifo.size()));
        chk("sh_data",    bus.sh_data,         h.d);
        chk("sh_num",     32'(bus.sh_num),     32'(h.n));
        chk("sh_type",    32'(bus.sh_type),    32'(h.t));
        chk("out_valid",  32'(bus.out_valid),  32'(m_ov));
        chk("out_result", bus.out_result,      m_res);
        chk("out_tag",    32'(bus.out_tag),    32'(m_tag));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    function automatic req_t rnd_req(input logic [TAGW-1:0] tag);
        req_t r;
        r.d = $urandom; r.n = 5'($urandom); r.t = 2'($urandom); r.tag = tag;
        return r;
    endfunction

    req_t        r;
    logic [31:0] exp_type [4];
    int          acc, maxc;
    logic [TAGW-1:0] seen[$];

    initial begin
        exp_type[0] = 32'hfffc0014; exp_type[1] = 32'h3fffc001;
        exp_type[2] = 32'hffffc001; exp_type[3] = 32'h7fffc001;
        reset = 1'b0;
        drive(0, '0, 0, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b1;

        // One request of each type, two edges from accept to output.
        for (int t = 0; t < 4; t++) begin
            r = '{d: 32'hffff0005, n: 5'd2, t: 2'(t), tag: TAGW'(t)};
            drive(1, r, 1, 0);
            step();
            drive(0, '0, 1, 0);
            chk("single_early_valid", 32'(bus.out_valid), 32'd0);
            step();
            chk("single_valid", 32'(bus.out_valid), 32'd1);
            chk("single_result", bus.out_result, exp_type[t]);
            chk("single_tag", 32'(bus.out_tag), 32'(t));
            step();
        end

        // Streaming with the consumer always ready.
        maxc = 0;
        seen.delete();
        for (int i = 0; i < 11; i++) begin
            if (i < 8) drive(1, rnd_req(TAGW'(i)), 1, 0);
            else       drive(0, '0, 1, 0);
            step();
            if (count > maxc) maxc = count;
            if (bus.out_valid) seen.push_back(bus.out_tag);
        end
        chk("stream_maxcount", 32'(maxc), 32'd1);
        chk("stream_n", 32'(seen.size()), 32'd8);
        for (int i = 0; i < seen.size(); i++) chk("stream_order", 32'(seen[i]), 32'(i));

        // Back-pressure until full.
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1, rnd_req(TAGW'(i)), 0, 0);
            if (bus.in_ready) acc++;
            step();
        end
        chk("bp_accepts", 32'(acc), 32'd5);
        chk("bp_count", 32'(count), 32'd4);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_tag", 32'(bus.out_tag), 32'd0);

        // Full: first cycle only pops, next accepts while popping.
        drive(1, rnd_req(4'd9), 1, 0);
        chk("full_no_accept", 32'(bus.in_ready), 32'd0);
        step();
        chk("full_count_a", 32'(count), 32'd3);
        drive(1, rnd_req(4'd10), 1, 0);
        chk("full_accept", 32'(bus.in_ready), 32'd1);
        step();
        chk("full_count_b", 32'(count), 32'd3);
        drive(0, '0, 1, 0);
        for (int i = 0; i < 6; i++) step();

        // Flush with three queued and the output held.
        for (int i = 0; i < 4; i++) begin
            drive(1, rnd_req(TAGW'(i)), 0, 0);
            step();
        end
        chk("pre_flush_count", 32'(count), 32'd3);
        chk("pre_flush_ov", 32'(bus.out_valid), 32'd1);
        drive(1, rnd_req(4'd12), 0, 1);
        step();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_ov", 32'(bus.out_valid), 32'd0);
        drive(0, '0, 0, 0);
        step();
        chk("flush_dropped", 32'(count), 32'd0);

        // Asynchronous reset between edges while holding data.
        for (int i = 0; i < 3; i++) begin
            drive(1, rnd_req(TAGW'(i + 3)), 0, 0);
            step();
        end
        drive(0, '0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
        check_all();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, rnd_req(TAGW'($urandom)),
                  ($urandom % 3) != 0, ($urandom % 40) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
